// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Arbitrates the single common data bus (CDB) between the result producers
// (index 0 = ALU, 1 = LSB load path, 2 = branch unit). One requester is granted
// per cycle in round-robin order. The winning result is registered and
// broadcast for exactly one cycle to every snooper (dispatcher, RS, LSB, RoB).
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous reset, active low
//   rdy_in          global ready; 0 freezes every register
//   flush_in        mispredict flush; only acted on while rdy_in = 1
//   req_valid_in    per-requester result valid
//   req_rob_id_in   per-requester RoB tag, requester i at [i*ROB_WIDTH +: ROB_WIDTH]
//   req_value_in    per-requester result,  requester i at [i*XLEN +: XLEN]
//   req_ready_out   one-hot grant, combinational
//   cdb_valid_out   broadcast valid (registered)
//   cdb_rob_id_out  broadcast RoB tag
//   cdb_value_out   broadcast value
//   cdb_src_out     index of the requester that produced the broadcast
//
// SRC_WIDTH must be wide enough to index NUM_REQ requesters.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ROB_WIDTH = 4,
    parameter int XLEN      = 32,
    parameter int SRC_WIDTH = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*ROB_WIDTH-1:0]  req_rob_id_in,
    input  logic [NUM_REQ*XLEN-1:0]       req_value_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic                          cdb_valid_out,
    output logic [ROB_WIDTH-1:0]          cdb_rob_id_out,
    output logic [XLEN-1:0]               cdb_value_out,
    output logic [SRC_WIDTH-1:0]          cdb_src_out
);

    // Round-robin successor with explicit wrap, so NUM_REQ need not be a power of two.
    function automatic logic [SRC_WIDTH-1:0] next_idx(input logic [SRC_WIDTH-1:0] idx);
        logic [SRC_WIDTH-1:0] nxt;
        if (idx == SRC_WIDTH'(NUM_REQ - 1)) begin
            nxt = {SRC_WIDTH{1'b0}};
        end else begin
            nxt = idx + SRC_WIDTH'(1);
        end
        return nxt;
    endfunction

    logic [SRC_WIDTH-1:0] rr_ptr_q,    rr_ptr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_WIDTH-1:0] cdb_rob_q,   cdb_rob_d;
    logic [XLEN-1:0]      cdb_value_q, cdb_value_d;
    logic [SRC_WIDTH-1:0] cdb_src_q,   cdb_src_d;

    logic                 grant_found_s;
    logic [SRC_WIDTH-1:0] grant_idx_s;
    logic                 grant_en_s;
    logic [ROB_WIDTH-1:0] sel_rob_s;
    logic [XLEN-1:0]      sel_value_s;

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        logic [SRC_WIDTH-1:0] cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = {SRC_WIDTH{1'b0}};
        cand_v        = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && req_valid_in[cand_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v;
            end else begin
                grant_found_s = grant_found_s;
            end
            cand_v = next_idx(cand_v);
        end
    end

    // No grant while paused, flushing or held in reset.
    assign grant_en_s = grant_found_s & rdy_in & ~flush_in & rst_in;

    // One-hot ready and payload selection for the winning requester.
    always_comb begin
        req_ready_out = {NUM_REQ{1'b0}};
        sel_rob_s     = {ROB_WIDTH{1'b0}};
        sel_value_s   = {XLEN{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == SRC_WIDTH'(i)) begin
                req_ready_out[i] = grant_en_s;
                sel_rob_s        = req_rob_id_in[i*ROB_WIDTH +: ROB_WIDTH];
                sel_value_s      = req_value_in[i*XLEN +: XLEN];
            end else begin
                req_ready_out[i] = 1'b0;
            end
        end
    end

    // Next-state: pause holds everything, flush clears valid and pointer,
    // otherwise broadcast the winner or drop valid when nobody requests.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        if (!rdy_in) begin
            rr_ptr_d = rr_ptr_q;
        end else if (flush_in) begin
            cdb_valid_d = 1'b0;
            rr_ptr_d    = {SRC_WIDTH{1'b0}};
        end else if (grant_en_s) begin
            cdb_valid_d = 1'b1;
            cdb_rob_d   = sel_rob_s;
            cdb_value_d = sel_value_s;
            cdb_src_d   = grant_idx_s;
            rr_ptr_d    = next_idx(grant_idx_s);
        end else begin
            cdb_valid_d = 1'b0;
        end
    end

    // State and broadcast registers; reset clears the bus immediately.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_q    <= {SRC_WIDTH{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= {ROB_WIDTH{1'b0}};
            cdb_value_q <= {XLEN{1'b0}};
            cdb_src_q   <= {SRC_WIDTH{1'b0}};
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_rob_id_out = cdb_rob_q;
    assign cdb_value_out  = cdb_value_q;
    assign cdb_src_out    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed-vector bench for cdb_arbiter. Each requester carries a fixed
// payload (rob id / value); expected grants and broadcasts are hand-computed.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int ROB_WIDTH = 4;
    localparam int XLEN      = 32;
    localparam int SRC_WIDTH = 2;

    logic                         clk_in;
    logic                         rst_in;
    logic                         rdy_in;
    logic                         flush_in;
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ*ROB_WIDTH-1:0] req_rob_id_in;
    logic [NUM_REQ*XLEN-1:0]      req_value_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic                         cdb_valid_out;
    logic [ROB_WIDTH-1:0]         cdb_rob_id_out;
    logic [XLEN-1:0]              cdb_value_out;
    logic [SRC_WIDTH-1:0]         cdb_src_out;

    int n_checks;
    int n_errors;

    // Fixed payloads: req0 rob 3, req1 rob 5, req2 rob 9
    localparam logic [ROB_WIDTH-1:0] ROB0 = 4'h3;
    localparam logic [ROB_WIDTH-1:0] ROB1 = 4'h5;
    localparam logic [ROB_WIDTH-1:0] ROB2 = 4'h9;
    localparam logic [XLEN-1:0]      VAL0 = 32'h1111_0000;
    localparam logic [XLEN-1:0]      VAL1 = 32'hDEAD_BEEF;
    localparam logic [XLEN-1:0]      VAL2 = 32'h2222_2222;

    cdb_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ROB_WIDTH (ROB_WIDTH),
        .XLEN      (XLEN),
        .SRC_WIDTH (SRC_WIDTH)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .req_valid_in   (req_valid_in),
        .req_rob_id_in  (req_rob_id_in),
        .req_value_in   (req_value_in),
        .req_ready_out  (req_ready_out),
        .cdb_valid_out  (cdb_valid_out),
        .cdb_rob_id_out (cdb_rob_id_out),
        .cdb_value_out  (cdb_value_out),
        .cdb_src_out    (cdb_src_out)
    );

    // 10-unit clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Check the whole broadcast bus.
    task automatic check_bus(input string tag, input logic v, input logic [ROB_WIDTH-1:0] rob,
                             input logic [XLEN-1:0] val, input logic [SRC_WIDTH-1:0] src);
        check_val({tag, ".valid"}, 64'(cdb_valid_out),  64'(v));
        check_val({tag, ".rob"},   64'(cdb_rob_id_out), 64'(rob));
        check_val({tag, ".value"}, 64'(cdb_value_out),  64'(val));
        check_val({tag, ".src"},   64'(cdb_src_out),    64'(src));
    endtask

    task automatic set_valid(input logic [NUM_REQ-1:0] v);
        req_valid_in = v;
        #1;
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_rdy;
        n_checks      = 0;
        n_errors      = 0;
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        req_valid_in  = 3'b111;
        req_rob_id_in = {ROB2, ROB1, ROB0};
        req_value_in  = {VAL2, VAL1, VAL0};

        // 1: reset held with all requests valid
        tick();
        tick();
        check_val("rst.ready", 64'(req_ready_out), 64'(3'b000));
        check_bus("rst", 1'b0, 4'h0, 32'h0, 2'd0);
        #3;
        rst_in = 1'b1;
        #1;
        check_val("t1.ready", 64'(req_ready_out), 64'(3'b001));
        tick();
        check_bus("t1.bc", 1'b1, ROB0, VAL0, 2'd0);
        set_valid(3'b000);
        check_val("t1.idle_ready", 64'(req_ready_out), 64'(3'b000));
        tick();
        check_val("t1.drop", 64'(cdb_valid_out), 64'(1'b0));

        // 2: only req1 valid (rr_ptr = 1)
        set_valid(3'b010);
        check_val("t2.ready", 64'(req_ready_out), 64'(3'b010));
        tick();
        check_bus("t2.bc", 1'b1, ROB1, VAL1, 2'd1);
        set_valid(3'b000);
        tick();
        check_val("t2.drop", 64'(cdb_valid_out), 64'(1'b0));

        // 4: grant req2 (rr_ptr wraps to 0), then req0 and req2 together
        set_valid(3'b100);
        check_val("t4.ready_a", 64'(req_ready_out), 64'(3'b100));
        tick();
        check_bus("t4.bc_a", 1'b1, ROB2, VAL2, 2'd2);
        set_valid(3'b101);
        check_val("t4.ready_b", 64'(req_ready_out), 64'(3'b001));
        tick();
        check_bus("t4.bc_b", 1'b1, ROB0, VAL0, 2'd0);
        set_valid(3'b100);
        check_val("t4.ready_c", 64'(req_ready_out), 64'(3'b100));
        tick();
        check_bus("t4.bc_c", 1'b1, ROB2, VAL2, 2'd2);

        // 3: all valid for 6 cycles from rr_ptr = 0
        set_valid(3'b111);
        for (int k = 0; k < 6; k++) begin
            exp_rdy = 3'b001 << (k % 3);
            check_val($sformatf("t3.ready%0d", k), 64'(req_ready_out), 64'(exp_rdy));
            tick();
            check_val($sformatf("t3.valid%0d", k), 64'(cdb_valid_out), 64'(1'b1));
            check_val($sformatf("t3.src%0d", k),   64'(cdb_src_out),   64'(k % 3));
        end

        // 5: broadcast src0 then pause 3 cycles with req1 waiting
        set_valid(3'b001);
        tick();
        check_bus("t5.bc0", 1'b1, ROB0, VAL0, 2'd0);
        rdy_in = 1'b0;
        set_valid(3'b010);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("t5.ready%0d", k), 64'(req_ready_out), 64'(3'b000));
            tick();
            check_bus($sformatf("t5.hold%0d", k), 1'b1, ROB0, VAL0, 2'd0);
        end
        rdy_in = 1'b1;
        #1;
        check_val("t5.ready_go", 64'(req_ready_out), 64'(3'b010));
        tick();
        check_bus("t5.bc1", 1'b1, ROB1, VAL1, 2'd1);

        // 6: flush with all valid (rr_ptr was 2), then resume
        flush_in = 1'b1;
        set_valid(3'b111);
        check_val("t6.ready_fl", 64'(req_ready_out), 64'(3'b000));
        tick();
        check_val("t6.valid_fl", 64'(cdb_valid_out), 64'(1'b0));
        flush_in = 1'b0;
        #1;
        check_val("t6.rr_zero", 64'(req_ready_out), 64'(3'b001));
        set_valid(3'b100);
        check_val("t6.ready2", 64'(req_ready_out), 64'(3'b100));
        tick();
        check_bus("t6.bc2", 1'b1, ROB2, VAL2, 2'd2);
        set_valid(3'b000);
        tick();
        check_val("t6.drop", 64'(cdb_valid_out), 64'(1'b0));

        // Reset mid-broadcast drops valid without a clock edge
        set_valid(3'b010);
        tick();
        check_val("ar.pre", 64'(cdb_valid_out), 64'(1'b1));
        req_valid_in = 3'b000;
        #1;
        rst_in = 1'b0;
        #1;
        check_bus("ar.async", 1'b0, 4'h0, 32'h0, 2'd0);
        rst_in = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
